// File: rtl/tpu_stream_core.sv
// tpu_stream_core: output-stationary N x M systolic matrix-multiply core with
// jointly handshaked A/B operand streams and a valid/ready serial result drain.
module tpu_stream_core #(
  parameter int N      = 4,
  parameter int M      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_MAX  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  input  logic                         acc_mode,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [N*DATA_W-1:0]          a_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [M*DATA_W-1:0]          b_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         err
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int CW = $clog2(K_MAX + N + M + 1);
  localparam int IW = (N * M > 1) ? $clog2(N * M) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
  state_t state, nxt;
  logic [KW-1:0] k_r;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic bad, go, clr, beat, take;
  logic signed [DATA_W-1:0] a_in [N], a_sk [N], a_dl [N][N];
  logic signed [DATA_W-1:0] b_in [M], b_sk [M], b_dl [M][M];
  logic signed [DATA_W-1:0] a_w [N][M], b_w [N][M], a_q [N][M], b_q [N][M];
  logic signed [ACC_W-1:0] acc [N*M];
  function automatic logic signed [ACC_W-1:0] sx(input logic signed [DATA_W-1:0] v);
    return ACC_W'(v);
  endfunction
  assign bad       = k_len == '0 || k_len > KW'(K_MAX);
  assign go        = state == IDLE && start && !bad;
  assign clr       = go && !acc_mode;
  assign beat      = state == LOAD && a_valid && b_valid;
  assign a_ready   = state == LOAD && b_valid;
  assign b_ready   = state == LOAD && a_valid;
  assign busy      = state != IDLE;
  assign out_valid = state == DRAIN;
  assign out_last  = out_valid && idx == IW'(N * M - 1);
  assign out_data  = out_valid ? acc[idx] : '0;
  assign take      = out_valid && out_ready;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = go ? LOAD : IDLE;
      LOAD:    nxt = (beat && cnt + CW'(1) == CW'(k_r)) ? FLUSH : LOAD;
      FLUSH:   nxt = cnt == CW'(N + M - 2) ? DRAIN : FLUSH;
      default: nxt = (take && out_last) ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      k_r   <= '0;
      cnt   <= '0;
      idx   <= '0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      k_r   <= go ? k_len : k_r;
      cnt   <= state != nxt ? '0 : (beat || state == FLUSH) ? cnt + CW'(1) : cnt;
      idx   <= take ? (out_last ? '0 : idx + IW'(1)) : idx;
      err   <= start && (state != IDLE || bad);
    end
  // Skew: row i of A / column j of B enters the array i / j cycles late; idle cycles inject zeros.
  always_comb begin
    for (int i = 0; i < N; i++) a_in[i] = beat ? a_data[i*DATA_W +: DATA_W] : '0;
    for (int j = 0; j < M; j++) b_in[j] = beat ? b_data[j*DATA_W +: DATA_W] : '0;
    a_sk[0] = a_in[0];
    b_sk[0] = b_in[0];
    for (int i = 1; i < N; i++) a_sk[i] = a_dl[i][i-1];
    for (int j = 1; j < M; j++) b_sk[j] = b_dl[j][j-1];
    for (int i = 0; i < N; i++) begin
      a_w[i][0] = a_sk[i];
      for (int j = 1; j < M; j++) a_w[i][j] = a_q[i][j-1];
    end
    for (int j = 0; j < M; j++) begin
      b_w[0][j] = b_sk[j];
      for (int i = 1; i < N; i++) b_w[i][j] = b_q[i-1][j];
    end
  end
  // PEs multiply their registered operands, so the last beat lands in the final FLUSH cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N; i++) for (int d = 0; d < N; d++) a_dl[i][d] <= '0;
      for (int j = 0; j < M; j++) for (int d = 0; d < M; d++) b_dl[j][d] <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < M; j++) begin
          a_q[i][j]     <= '0;
          b_q[i][j]     <= '0;
          acc[i*M + j]  <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_dl[i][0] <= a_in[i];
        for (int d = 1; d < N; d++) a_dl[i][d] <= a_dl[i][d-1];
      end
      for (int j = 0; j < M; j++) begin
        b_dl[j][0] <= b_in[j];
        for (int d = 1; d < M; d++) b_dl[j][d] <= b_dl[j][d-1];
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < M; j++) begin
          a_q[i][j]    <= a_w[i][j];
          b_q[i][j]    <= b_w[i][j];
          acc[i*M + j] <= clr ? '0 : state == DRAIN ? acc[i*M + j]
                        : acc[i*M + j] + sx(a_q[i][j]) * sx(b_q[i][j]);
        end
    end
endmodule

// File: tb/tb_tpu_stream_core.sv
// tb_tpu_stream_core: directed + random runs on 32-bit and 16-bit accumulator instances
// sharing one stimulus, checked against a plain-arithmetic matrix-product model.
module tb_tpu_stream_core;
  localparam int N = 4, M = 4, DW = 8, KM = 16;
  logic clk = 0, rst = 0, start = 0, acc_mode = 0, a_valid = 0, b_valid = 0, out_ready = 0;
  logic [4:0] k_len = '0;
  logic [N*DW-1:0] a_data = '0;
  logic [M*DW-1:0] b_data = '0;
  logic a_ready, b_ready, out_valid, out_last, busy, err;
  logic [31:0] out_data;
  logic a_ready16, b_ready16, out_valid16, out_last16, busy16, err16;
  logic [15:0] out_data16;
  int ncmp = 0, nerr = 0;
  logic signed [7:0] ga [N][KM];
  logic signed [7:0] gb [KM][M];
  longint mc [N*M];

  always #5 clk = ~clk;

  tpu_stream_core #(.N(N), .M(M), .DATA_W(DW), .ACC_W(32), .K_MAX(KM)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_mode(acc_mode),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err(err));

  tpu_stream_core #(.N(N), .M(M), .DATA_W(DW), .ACC_W(16), .K_MAX(KM)) dut16 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_mode(acc_mode),
    .a_valid(a_valid), .a_ready(a_ready16), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready16), .b_data(b_data),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_last(out_last16), .busy(busy16), .err(err16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_run(input int k, input bit mode);
    for (int x = 0; x < N*M; x++) if (!mode) mc[x] = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        for (int kk = 0; kk < k; kk++)
          mc[i*M + j] += longint'(ga[i][kk]) * longint'(gb[kk][j]);
  endtask

  task automatic put_beat(input int kk);
    for (int i = 0; i < N; i++) a_data[i*DW +: DW] = ga[i][kk];
    for (int j = 0; j < M; j++) b_data[j*DW +: DW] = gb[kk][j];
  endtask

  // orm: 0 = out_ready held high, 1 = alternating 1/0, 2 = random
  task automatic run(input int k, input bit mode, input int lag, input int orm, input bit derr);
    int n, g, lat;
    bit fired, pend;
    start = 1; k_len = 5'(k); acc_mode = mode;
    tick();
    start = 0;
    chk("busy_load", busy, 1);
    model_run(k, mode);
    for (int kk = 0; kk < k; kk++) begin
      put_beat(kk);
      a_valid = 1; b_valid = (lag == 0);
      for (int l = 0; l < lag; l++) tick();
      if (lag > 0) begin
        chk("a_ready_wait", a_ready, 0);
        chk("b_ready_wait", b_ready, 1);
      end
      b_valid = 1;
      tick();
    end
    a_valid = 0; b_valid = 0;
    chk("ready_flush", a_ready, 0);
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    chk("latency", lat, N + M);
    n = 0; g = 0; fired = 0;
    while (n < N*M && g < 300) begin
      out_ready = (orm == 0) || (orm == 1 && g % 2 == 0) || (orm == 2 && $urandom_range(0, 1) == 1);
      pend = 0;
      if (derr && !fired && n == 5) begin start = 1; fired = 1; pend = 1; end
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, mc[n][31:0]);
      chk("out_data16", out_data16, mc[n][15:0]);
      chk("out_last", out_last, n == N*M - 1);
      tick();
      start = 0;
      if (pend) chk("err_drain", err, 1);
      if (out_ready) n++;
      g++;
    end
    out_ready = 0;
    chk("drain_count", n, N*M);
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_err", err, 0);
  endtask

  task automatic bad_start(input int k);
    start = 1; k_len = 5'(k); acc_mode = 0;
    tick();
    start = 0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    tick();
    chk("err_clear", err, 0);
  endtask

  task automatic fill(input int av, input int bv);
    for (int i = 0; i < N; i++) for (int kk = 0; kk < KM; kk++) ga[i][kk] = 8'(av);
    for (int kk = 0; kk < KM; kk++) for (int j = 0; j < M; j++) gb[kk][j] = 8'(bv);
  endtask

  task automatic fill_identity();
    for (int i = 0; i < N; i++) for (int kk = 0; kk < KM; kk++) ga[i][kk] = (i == kk) ? 8'sd1 : 8'sd0;
    for (int kk = 0; kk < KM; kk++) for (int j = 0; j < M; j++) gb[kk][j] = 8'(4*kk + j + 1);
  endtask

  initial begin
    #1 rst = 1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    tick(); tick();
    rst = 0;
    for (int x = 0; x < N*M; x++) mc[x] = 0;

    fill_identity();
    run(4, 0, 0, 0, 0);
    run(4, 0, 3, 1, 0);
    for (int x = 0; x < N*M; x++) chk("identity_value", mc[x], x + 1);

    fill(1, 1);
    run(4, 0, 0, 0, 0);
    run(4, 1, 0, 1, 0);
    run(4, 0, 0, 0, 0);
    chk("ones_value", mc[N*M-1], 4);

    fill(-128, 127);
    run(1, 0, 0, 0, 0);
    chk("signed_value", mc[0][31:0], 32'hFFFFC080);
    fill(-128, -128);
    run(16, 0, 0, 2, 0);
    chk("wrap16_value", mc[0][15:0], 16'h0000);

    bad_start(0);
    bad_start(17);
    fill_identity();
    run(4, 0, 0, 1, 1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) for (int kk = 0; kk < KM; kk++) ga[i][kk] = 8'($urandom);
      for (int kk = 0; kk < KM; kk++) for (int j = 0; j < M; j++) gb[kk][j] = 8'($urandom);
      run($urandom_range(1, KM), r > 0 && $urandom_range(0, 1) == 1, $urandom_range(0, 2), 2, r == 3);
    end

    fill_identity();
    start = 1; k_len = 5'd4; acc_mode = 0;
    tick();
    start = 0;
    for (int kk = 0; kk < 2; kk++) begin
      put_beat(kk); a_valid = 1; b_valid = 1;
      tick();
    end
    rst = 1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_last", out_last, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    chk("midrst_a_ready", a_ready, 0);
    chk("midrst_b_ready", b_ready, 0);
    tick();
    rst = 0; a_valid = 0; b_valid = 0;
    for (int x = 0; x < N*M; x++) mc[x] = 0;
    run(4, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/tpu_stream_core.md
Name: tpu_stream_core

Overview:
Next-generation parametrised matrix-multiply core with handshaked operand streams.
- Computes C[N][M] = sum over k of A[N][k]*B[k][M], with K set per run up to K_MAX.
- Uses an output-stationary N x M systolic PE array with internal input skew, accumulate/clear mode, and a valid/ready serial drain of results.
- Replaces the controller/buffer/delay/PISO chain with one streaming block fed directly by the host-side datapath.

Parameters:
N, 4, rows of A and C (PE rows)
M, 4, columns of B and C (PE columns)
DATA_W, 8, signed operand width
ACC_W, 32, signed accumulator/output width (ACC_W >= 2*DATA_W)
K_MAX, 16, maximum inner dimension per run

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  run request pulse, sampled in IDLE
k_len  input  $clog2(K_MAX+1)  inner dimension K, latched on accepted start
acc_mode  input  1  latched on start; 0 = clear accumulators, 1 = accumulate onto previous C
a_valid  input  1  A column beat valid
a_ready  output  1  A beat accepted
a_data  input  N*DATA_W  element i at [i*DATA_W +: DATA_W] = A[i][k]
b_valid  input  1  B row beat valid
b_ready  output  1  B beat accepted
b_data  input  M*DATA_W  element j at [j*DATA_W +: DATA_W] = B[k][j]
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  ACC_W  C[i][j], row-major
out_last  output  1  high with C[N-1][M-1]
busy  output  1  high in any state other than IDLE
err  output  1  one-cycle error pulse

Behaviour:
- Reset: one clock, asynchronous active-high. All outputs 0, state IDLE, all accumulators, skew registers and counters 0. Reset mid-run aborts with no further outputs.
- FSM: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
- IDLE:
  - start with 1 <= k_len <= K_MAX: latch k_len and acc_mode, go to LOAD next cycle. If acc_mode=0, all accumulators clear that cycle.
  - start with k_len=0 or k_len>K_MAX: err=1 next cycle, remain IDLE.
- Start outside IDLE: ignored, err pulse, run unaffected.
- LOAD, joint handshake:
  - a_ready = LOAD && b_valid; b_ready = LOAD && a_valid.
  - A beat is consumed only when a_valid && b_valid, so both streams advance together.
  - Cycles without a beat inject zeros into the skew inputs (bubbles).
  - Beat counter counts to k_len; the cycle the k_len-th beat is accepted, go to FLUSH.
  - a_ready and b_ready are 0 outside LOAD.
- Skew and array:
  - Row i of A is delayed i cycles; column j of B is delayed j cycles.
  - PE(i,j) registers its a and b inputs and passes them right/down.
  - Each cycle: acc += sign_ext(a)*sign_ext(b), two's complement, wrapping modulo 2^ACC_W.
  - Zero bubbles contribute 0.
- FLUSH: lasts exactly N+M-1 cycles so the last beat reaches PE(N-1,M-1); zeros are injected throughout. Then go to DRAIN.
- DRAIN:
  - Accumulators frozen. out_valid=1, out_data=C[idx], with idx starting at 0, row-major (idx = i*M+j).
  - idx increments only on out_valid && out_ready. out_data and out_last stay stable while stalled.
  - out_last=1 when idx = N*M-1. Its acceptance returns to IDLE, with out_valid=0 next cycle.
- Latency (no bubbles, out_ready=1): first out_valid at cycle (last beat acceptance + N+M). N*M results on consecutive cycles.
- Accumulators persist in IDLE across runs; acc_mode=1 sums successive runs (K-splitting).

Test Plan:
- Identity: k_len=4, acc_mode=0, A=I, B[k][j]=4k+j+1, contiguous beats, out_ready=1 -> outputs 1..16 in order, out_last only on 16, busy drops after.
- Backpressure/bubbles: same data, b_valid lags a_valid by 3 cycles per beat, out_ready alternating 1/0 -> identical 16 results, no duplicates or drops, out_data stable in stall cycles.
- Accumulate mode: A=B=all ones, k_len=4.
  - Run 1 with acc_mode=0 -> all C=4.
  - Run 2 with acc_mode=1 -> all 8.
  - Run 3 with acc_mode=0 -> all 4.
- Signed/wrap: k_len=1, A=-128, B=127 -> all C=0xFFFFC080. With ACC_W=16, A=B=-128, k_len=16 -> all C=0x0000.
- Errors: start with k_len=0 -> err pulse, busy=0. start with k_len=17 -> err pulse. start during DRAIN -> err pulse, drain sequence unchanged.
- Reset: assert rst mid-LOAD after 2 beats -> all outputs 0 immediately. A subsequent identity run yields correct 1..16.
